muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the M-extension ops the instruction decoder flags: MUL, DIV/DIVU and REM/REMU.
- Accepts one operation per handshake from the execute stage.
- Runs a radix-2 shift-add multiply or a restoring divide, one bit per clock.
- Applies RISC-V sign and special-case rules, then holds the result until the writeback stage takes it.
- Drives `stall` to freeze fetch/decode while busy.

---
 rtl/muldiv_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV/REM sequencer: radix-2 shift-add multiply and restoring divide,
// one bit per clock, with RISC-V sign and special-case handling in a final FIXUP cycle.
module muldiv_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int REGADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [1:0]               opSelect,
    input  logic                     unsignedSelect,
    input  logic [DATA_WIDTH-1:0]    operandA,
    input  logic [DATA_WIDTH-1:0]    operandB,
    input  logic [REGADDR_WIDTH-1:0] writeSelectIn,
    input  logic                     abort,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [REGADDR_WIDTH-1:0] writeSelectOut,
    output logic                     opError,
    output logic                     stall
);

    // state  | meaning
    // IDLE   | waiting for an operation, start_ready high
    // MUL    | shift-add multiply, one multiplier bit per clock
    // DIV    | restoring divide on magnitudes, one quotient bit per clock
    // FIXUP  | apply signs / special cases, write result
    // DONE   | result_valid high until writeback takes it
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;
    localparam logic [DATA_WIDTH-1:0] LP_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [5:0]            LP_LAST = 6'(DATA_WIDTH - 1);

    state_t                   r_state, w_next;
    logic [5:0]               r_cnt;
    logic [DATA_WIDTH-1:0]    r_x;      // multiplicand, or dividend shifting into quotient
    logic [DATA_WIDTH-1:0]    r_y;      // multiplier, or divisor magnitude
    logic [DATA_WIDTH-1:0]    r_acc;    // product, or partial remainder
    logic [DATA_WIDTH-1:0]    r_opa;
    logic [DATA_WIDTH-1:0]    r_opb;
    logic [DATA_WIDTH-1:0]    r_result;
    logic [1:0]               r_op;
    logic                     r_uns;
    logic                     r_err;
    logic [REGADDR_WIDTH-1:0] r_wsel;

    logic                  w_accept, w_is_div, w_sgn, w_special, w_last;
    logic [DATA_WIDTH-1:0] w_mag_a, w_mag_b;
    logic [DATA_WIDTH:0]   w_shift, w_diff;
    logic                  w_fits;
    logic                  w_sa, w_sb, w_zero, w_ovf;
    logic [DATA_WIDTH-1:0] w_fix_res;
    logic                  w_fix_err;

    assign w_accept  = (r_state == S_IDLE) && start_valid;
    assign w_is_div  = (opSelect == OP_DIV) || (opSelect == OP_REM);
    assign w_sgn     = w_is_div && !unsignedSelect;
    assign w_mag_a   = (w_sgn && operandA[DATA_WIDTH-1]) ? -operandA : operandA;
    assign w_mag_b   = (w_sgn && operandB[DATA_WIDTH-1]) ? -operandB : operandB;
    assign w_special = (opSelect == OP_RSV) ||
                       (w_is_div && ((operandB == '0) ||
                        (!unsignedSelect && operandA == LP_MIN && operandB == '1)));
    assign w_last    = (r_cnt == LP_LAST);

    assign w_shift = {r_acc, r_x[DATA_WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_y};
    assign w_fits  = !w_diff[DATA_WIDTH];

    assign w_sa   = !r_uns && r_opa[DATA_WIDTH-1];
    assign w_sb   = !r_uns && r_opb[DATA_WIDTH-1];
    assign w_zero = (r_opb == '0);
    assign w_ovf  = !r_uns && (r_opa == LP_MIN) && (r_opb == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    if (w_special)              w_next = S_FIXUP;
                    else if (opSelect == OP_MUL) w_next = S_MUL;
                    else                         w_next = S_DIV;
                end
            end
            S_MUL:   if (w_last) w_next = S_FIXUP;
            S_DIV:   if (w_last) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE:  if (result_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (r_state != S_IDLE && abort) w_next = S_IDLE;
    end

    always_comb begin
        w_fix_res = '0;
        w_fix_err = 1'b0;
        case (r_op)
            OP_MUL: w_fix_res = r_acc;
            OP_DIV: begin
                if (w_zero)         w_fix_res = '1;
                else if (w_ovf)     w_fix_res = LP_MIN;
                else if (w_sa ^ w_sb) w_fix_res = -r_x;
                else                w_fix_res = r_x;
            end
            OP_REM: begin
                if (w_zero)     w_fix_res = r_opa;
                else if (w_ovf) w_fix_res = '0;
                else if (w_sa)  w_fix_res = -r_acc;
                else            w_fix_res = r_acc;
            end
            default: w_fix_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_op     <= OP_MUL;
            r_uns    <= 1'b0;
            r_err    <= 1'b0;
            r_wsel   <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_opa  <= operandA;
            r_opb  <= operandB;
            r_op   <= opSelect;
            r_uns  <= unsignedSelect;
            r_wsel <= writeSelectIn;
            r_x    <= (opSelect == OP_MUL) ? operandA : w_mag_a;
            r_y    <= (opSelect == OP_MUL) ? operandB : w_mag_b;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_acc <= r_acc + (r_y[0] ? r_x : '0);
                    r_x   <= r_x << 1;
                    r_y   <= r_y >> 1;
                    r_cnt <= (w_last || abort) ? '0 : r_cnt + 6'd1;
                end
                S_DIV: begin
                    r_acc <= w_fits ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
                    r_x   <= {r_x[DATA_WIDTH-2:0], w_fits};
                    r_cnt <= (w_last || abort) ? '0 : r_cnt + 6'd1;
                end
                S_FIXUP: begin
                    // an abort in this cycle drops the op before it becomes visible
                    if (!abort) begin
                        r_result <= w_fix_res;
                        r_err    <= w_fix_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready    = (r_state == S_IDLE);
    assign stall          = (r_state != S_IDLE);
    assign result_valid   = (r_state == S_DONE);
    assign result         = r_result;
    assign writeSelectOut = r_wsel;
    assign opError        = r_err;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results, latencies and control cases.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  opSelect;
    logic        unsignedSelect;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [4:0]  writeSelectIn;
    logic        abort;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic [4:0]  writeSelectOut;
    logic        opError;
    logic        stall;

    int n_vec;
    int n_err;

    muldiv_sequencer #(.DATA_WIDTH(32), .REGADDR_WIDTH(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .opSelect       (opSelect),
        .unsignedSelect (unsignedSelect),
        .operandA       (operandA),
        .operandB       (operandB),
        .writeSelectIn  (writeSelectIn),
        .abort          (abort),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result         (result),
        .writeSelectOut (writeSelectOut),
        .opError        (opError),
        .stall          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op for a single accepting edge (E0), then scrambles the inputs.
    task automatic start(input logic [1:0] op, input logic uns, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        opSelect       = op;
        unsignedSelect = uns;
        operandA       = a;
        operandB       = b;
        writeSelectIn  = rd;
        start_valid    = 1'b1;
        @(posedge clk); #1;
        start_valid    = 1'b0;
        opSelect       = ~op;
        unsignedSelect = ~uns;
        operandA       = ~a;
        operandB       = ~b;
        writeSelectIn  = ~rd;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (result_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic take();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic uns,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        start(op, uns, a, b, rd);
        chk({tag, ".stall"}, 32'(stall), 32'd1);
        wait_valid(lat);
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".res"}, result, exp);
        chk({tag, ".err"}, 32'(opError), 32'(op == 2'd3));
        chk({tag, ".rd"}, 32'(writeSelectOut), 32'(rd));
        take();
        chk({tag, ".vdrop"}, 32'(result_valid), 32'd0);
        chk({tag, ".rdy"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int hits;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        start_valid = 1'b0;
        opSelect = 2'd0;
        unsignedSelect = 1'b0;
        operandA = '0;
        operandB = '0;
        writeSelectIn = '0;
        abort = 1'b0;
        result_ready = 1'b0;
        #12;
        chk("rst.rdy", 32'(start_ready), 32'd1);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.valid", 32'(result_valid), 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.rd", 32'(writeSelectOut), 32'd0);
        chk("rst.err", 32'(opError), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("mul_neg", 2'd0, 1'b0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33);
        run_op("mul_nn", 2'd0, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFB, 5'd6, 32'd15, 33);
        run_op("mul_big", 2'd0, 1'b0, 32'h00012345, 32'h00000100, 5'd31, 32'h01234500, 33);

        run_op("div_s", 2'd1, 1'b0, 32'hFFFFFFEC, 32'd3, 5'd1, 32'hFFFFFFFA, 33);
        run_op("rem_s", 2'd2, 1'b0, 32'hFFFFFFEC, 32'd3, 5'd2, 32'hFFFFFFFE, 33);
        run_op("divu", 2'd1, 1'b1, 32'hFFFFFFEC, 32'd3, 5'd3, 32'h5555554E, 33);
        run_op("remu", 2'd2, 1'b1, 32'hFFFFFFEC, 32'd3, 5'd4, 32'h00000002, 33);
        run_op("div_negb", 2'd1, 1'b0, 32'd100, 32'hFFFFFFF9, 5'd8, 32'hFFFFFFF2, 33);
        run_op("rem_negb", 2'd2, 1'b0, 32'd100, 32'hFFFFFFF9, 5'd9, 32'h00000002, 33);

        run_op("div0", 2'd1, 1'b0, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 1);
        run_op("rem0", 2'd2, 1'b0, 32'd5, 32'd0, 5'd11, 32'h00000005, 1);
        run_op("divu0", 2'd1, 1'b1, 32'd5, 32'd0, 5'd12, 32'hFFFFFFFF, 1);
        run_op("remu0", 2'd2, 1'b1, 32'd5, 32'd0, 5'd13, 32'h00000005, 1);

        run_op("div_ovf", 2'd1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
        run_op("rem_ovf", 2'd2, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 1);
        run_op("divu_big", 2'd1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 33);
        run_op("remu_big", 2'd2, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 33);

        run_op("rsv", 2'd3, 1'b0, 32'd9, 32'd4, 5'd18, 32'h00000000, 1);
        run_op("after_rsv", 2'd0, 1'b0, 32'd6, 32'd7, 5'd19, 32'd42, 33);

        // abort after ten divide iterations
        start(2'd1, 1'b0, 32'd1000, 32'd7, 5'd20);
        hits = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (result_valid === 1'b1) hits++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort.stall", 32'(stall), 32'd0);
        chk("abort.rdy", 32'(start_ready), 32'd1);
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid === 1'b1) hits++;
        end
        chk("abort.nopulse", 32'(hits), 32'd0);

        // abort in IDLE does not block an accept
        abort = 1'b1;
        start(2'd0, 1'b0, 32'd3, 32'd4, 5'd21);
        abort = 1'b0;
        chk("idle_abort.stall", 32'(stall), 32'd1);
        wait_valid(lat);
        chk("idle_abort.lat", 32'(lat), 32'd33);
        chk("idle_abort.res", result, 32'd12);
        take();

        // abort wins over result_ready in DONE
        start(2'd1, 1'b1, 32'd50, 32'd5, 5'd22);
        wait_valid(lat);
        chk("done_abort.res", result, 32'd10);
        abort = 1'b1;
        result_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        result_ready = 1'b0;
        chk("done_abort.valid", 32'(result_valid), 32'd0);
        chk("done_abort.rdy", 32'(start_ready), 32'd1);

        // backpressure: DONE holds while a new request is ignored
        start(2'd1, 1'b1, 32'd1000, 32'd10, 5'd23);
        wait_valid(lat);
        chk("bp.lat", 32'(lat), 32'd33);
        opSelect = 2'd0;
        unsignedSelect = 1'b0;
        operandA = 32'd11;
        operandB = 32'd13;
        writeSelectIn = 5'd2;
        start_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp.res", result, 32'h00000064);
            chk("bp.valid", 32'(result_valid), 32'd1);
            chk("bp.rdy", 32'(start_ready), 32'd0);
            chk("bp.rd", 32'(writeSelectOut), 32'd23);
        end
        start_valid = 1'b0;
        take();
        chk("bp.vdrop", 32'(result_valid), 32'd0);
        chk("bp.hold", result, 32'h00000064);

        // asynchronous reset in the middle of a multiply
        start(2'd0, 1'b0, 32'd3, 32'd5, 5'd24);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst.stall", 32'(stall), 32'd0);
        chk("arst.rdy", 32'(start_ready), 32'd1);
        chk("arst.valid", 32'(result_valid), 32'd0);
        chk("arst.res", result, 32'd0);
        chk("arst.rd", 32'(writeSelectOut), 32'd0);
        chk("arst.err", 32'(opError), 32'd0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op("post_rst", 2'd0, 1'b0, 32'd9, 32'd9, 5'd25, 32'd81, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
